// File: rtl/divider_32bit_seq.sv
// rtl/divider_32bit_seq.sv - sequential restoring divider, one quotient bit per cycle
// Optional two's-complement mode enabled by defining DIVIDER_SIGNED_EN.
module divider_32bit_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
`ifdef DIVIDER_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic             neg_quo_d;
    logic             neg_rem_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             zero_div;

    // The core always divides magnitudes; sign fix-up is deferred to FINISH.
    always_comb begin
`ifdef DIVIDER_SIGNED_EN
        neg_rem_d = is_signed & Dividend[WIDTH-1];
        neg_quo_d = is_signed & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
        dvd_mag   = neg_rem_d ? -Dividend : Dividend;
        dsr_mag   = (is_signed & Divisor[WIDTH-1]) ? -Divisor : Divisor;
`else
        neg_rem_d = 1'b0;
        neg_quo_d = 1'b0;
        dvd_mag   = Dividend;
        dsr_mag   = Divisor;
`endif
    end

    assign zero_div = (divisor_q == '0);
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, divisor_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero divisor is detected from the latched copy on the first CALC cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (zero_div || cnt_q == CNT_W'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dividend_q  <= Dividend;
                        divisor_q   <= dsr_mag;
                        quo_q       <= dvd_mag;
                        rem_q       <= '0;
                        neg_quo_q   <= neg_quo_d;
                        neg_rem_q   <= neg_rem_d;
                        cnt_q       <= CNT_W'(WIDTH);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem_q <= trial[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= shifted[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FINISH: begin
                    Quotient    <= zero_div ? '1 : (neg_quo_q ? -quo_q : quo_q);
                    Remainder   <= zero_div ? dividend_q : (neg_rem_q ? -rem_q : rem_q);
                    div_by_zero <= zero_div;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32bit_seq.sv
// tb/tb_divider_32bit_seq.sv - randomized self-checking bench with behavioural divide model
module tb_divider_32bit_seq;

`ifdef DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic        is_signed_tb;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          acc;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt = 0;
    int   total = 0;
    int   bad = 0;

    divider_32bit_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
`ifdef DIVIDER_SIGNED_EN
        .is_signed   (is_signed_tb),
`endif
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    // Reference: plain integer division, truncating toward zero in signed mode.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        e.acc = 0;
        e.due = 0;
        e.dz  = 1'b0;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) begin
                chk("busy_low_at_done", 32'(busy), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done at edge %0d actual=1 required=0", edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_edge", edge_cnt, e.due);
                    chk("quotient", Quotient, e.q);
                    chk("remainder", Remainder, e.r);
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                end
            end else if (exp_q.size() != 0) begin
                if (edge_cnt >= exp_q[0].due) begin
                    total++;
                    bad++;
                    $display("FAIL done_timeout at edge %0d required edge %0d", edge_cnt, exp_q[0].due);
                    void'(exp_q.pop_front());
                end else if (edge_cnt >= exp_q[0].acc) begin
                    chk("busy_during_calc", 32'(busy), 32'd1);
                end
            end
        end
    end

    // Called at a negedge; start is accepted on the following posedge.
    task automatic push_start(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        logic s_eff;
        s_eff        = s & SIGNED_EN;
        Dividend     = a;
        Divisor      = b;
        is_signed_tb = s_eff;
        start        = 1'b1;
        e            = model(a, b, s_eff);
        e.acc        = edge_cnt + 1;
        e.due        = e.acc + ((b == 32'd0) ? 2 : 33);
        exp_q.push_back(e);
        @(negedge clk);
        start        = 1'b0;
        Dividend     = $urandom;
        Divisor      = $urandom;
        is_signed_tb = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s);
        push_start(a, b, s);
        drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_quotient"}, Quotient, 32'd0);
        chk({tag, "_remainder"}, Remainder, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_dz"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        exp_t p;
        logic [31:0] a, b;
        logic        s;
        int          sel;

        rst          = 1'b1;
        start        = 1'b1;
        Dividend     = 32'd100;
        Divisor      = 32'd7;
        is_signed_tb = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset_hold_start");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle_done_after_reset", 32'(done), 32'd0);

        p = model(32'd100, 32'd7, 1'b0);
        chk("pin_100_7_q", p.q, 32'd14);
        chk("pin_100_7_r", p.r, 32'd2);
        p = model(32'd1234, 32'd0, 1'b0);
        chk("pin_1234_0_q", p.q, 32'hFFFF_FFFF);
        chk("pin_1234_0_r", p.r, 32'd1234);
        p = model(32'd5, 32'd9, 1'b0);
        chk("pin_5_9_r", p.r, 32'd5);
        p = model(32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("pin_unsigned_fff9_q", p.q, 32'h7FFF_FFFC);
        p = model(32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("pin_signed_m7_2_q", p.q, 32'hFFFF_FFFD);
        chk("pin_signed_m7_2_r", p.r, 32'hFFFF_FFFF);
        p = model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("pin_overflow_q", p.q, 32'h8000_0000);

        run(32'd100, 32'd7, 1'b0);
        run(32'hFFFF_FFFF, 32'd1, 1'b0);
        run(32'd5, 32'd9, 1'b0);
        run(32'd1234, 32'd0, 1'b0);
        run(32'd10, 32'd3, 1'b0);

        // start while busy is dropped; start in the done cycle is taken
        push_start(32'd1000, 32'd10, 1'b0);
        repeat (4) @(negedge clk);
        Dividend = 32'd7;
        Divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        push_start(32'd9, 32'd2, 1'b0);
        drain();

        push_start(32'd555555, 32'd3, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("mid_op_reset");
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_reset_outputs("after_abort");
        run(32'd64, 32'd8, 1'b0);

        if (SIGNED_EN) begin
            run(32'hFFFF_FFF9, 32'd2, 1'b1);
            run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
            run(32'hFFFF_FFF9, 32'd2, 1'b0);
            run(32'hFFFF_FFF9, 32'd0, 1'b1);
        end

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 32'd0;
            else if (sel < 5)  b = $urandom_range(1, 255);
            else if (sel == 5) b = 32'hFFFF_FFFF;
            else               b = $urandom;
            sel = $urandom_range(0, 3);
            if (sel == 0)      a = $urandom_range(0, 1000);
            else if (sel == 1) a = 32'h8000_0000 | 32'($urandom_range(0, 3));
            else               a = $urandom;
            s = 1'($urandom_range(0, 1));
            push_start(a, b, s);
            if ($urandom_range(0, 3) == 0) wait_done();
            else                           drain();
        end
        drain();

        chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
